// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and JEDEC byte selection for the SPI flash responder.
package spi_flash_pkg;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_JEDEC = 8'h9F;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      DATA   = 3'd3,
      STAT   = 3'd4,
      ID     = 3'd5,
      IGNORE = 3'd6
   } state_e;

   // Byte idx of a 24-bit JEDEC id, idx 0 being the manufacturer (MSB) byte.
   function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = id[23:16];
         2'd1:    b = id[15:8];
         default: b = id[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Two-flop synchronizers for SCK, CS_n and MOSI, plus one history flop on SCK and
// CS_n for edge pulses. MOSI shares the SCK sync depth so the two stay aligned.
module spi_pin_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sck_i,
   input  logic cs_ni,
   input  logic mosi_i,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic cs_n_o,
   output logic cs_fall_o,
   output logic mosi_o
);

   logic [2:0] sck_q;
   logic [2:0] cs_q;
   logic [1:0] mosi_q;

   // CS_n history resets low so a select already active at reset release is not
   // mistaken for a fresh falling edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sck_q  <= 3'b000;
         cs_q   <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         sck_q  <= {sck_q[1:0], sck_i};
         cs_q   <= {cs_q[1:0], cs_ni};
         mosi_q <= {mosi_q[0], mosi_i};
      end
   end

   assign sck_rise_o = sck_q[1] & ~sck_q[2];
   assign sck_fall_o = ~sck_q[1] & sck_q[2];
   assign cs_n_o     = cs_q[1];
   assign cs_fall_o  = cs_q[2] & ~cs_q[1];
   assign mosi_o     = mosi_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating the read path of an SST25VF016B: READ, RDSR and
// JEDEC-ID, with data fetched from a byte-wide memory port with 1-cycle read latency.
//
// state  | meaning
// IDLE   | deselected, waiting for a CS_n fall
// CMD    | shifting in the opcode byte
// ADDR   | shifting in the 24-bit address
// DATA   | streaming memory bytes, address auto-increments
// STAT   | streaming the status byte
// ID     | streaming the 3 JEDEC id bytes cyclically
// IGNORE | unsupported opcode, MISO undriven until deselect
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int          ADDR_W   = 21,
   parameter logic [23:0] JEDEC_ID = 24'hBF2541,
   parameter logic [7:0]  STATUS   = 8'h1C
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              spi_sck_i,
   input  logic              spi_cs_ni,
   input  logic              spi_mosi_i,
   output logic              spi_miso_o,
   output logic              spi_miso_oe_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_rd_o,
   input  logic [7:0]        mem_data_i,
   output logic              cmd_valid_o,
   output logic [7:0]        cmd_o,
   output logic              err_o
);

   logic sck_rise, sck_fall, cs_n, cs_fall, mosi;

   spi_pin_sync u_sync (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .sck_i      (spi_sck_i),
      .cs_ni      (spi_cs_ni),
      .mosi_i     (spi_mosi_i),
      .sck_rise_o (sck_rise),
      .sck_fall_o (sck_fall),
      .cs_n_o     (cs_n),
      .cs_fall_o  (cs_fall),
      .mosi_o     (mosi)
   );

   state_e state_q, state_d;

   // Receive shifter keeps ADDR_W-1 bits; older address bits fall off the top,
   // which is how the unused upper address bits get discarded.
   logic [ADDR_W-2:0] rx_sr_q, rx_sr_d;
   logic [ADDR_W-1:0] rx_next;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        tx_sr_q, tx_sr_d;
   logic              miso_q, miso_d;
   logic              oe_q, oe_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              mem_rd_q, mem_rd_d;
   logic              load_q, load_d;
   logic [7:0]        cmd_q, cmd_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              err_q, err_d;
   logic [1:0]        id_idx_q, id_idx_d;
   logic [1:0]        id_idx_nxt;

   assign rx_next    = {rx_sr_q, mosi};
   assign id_idx_nxt = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a deselected bus overrides every state.
   always_comb begin
      state_d = state_q;
      if (cs_n) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (cs_fall) state_d = CMD;
            CMD: begin
               if (sck_rise && bit_cnt_q == 5'd7) begin
                  case (rx_next[7:0])
                     OP_READ:  state_d = ADDR;
                     OP_RDSR:  state_d = STAT;
                     OP_JEDEC: state_d = ID;
                     default:  state_d = IGNORE;
                  endcase
               end
            end
            ADDR: if (sck_rise && bit_cnt_q == 5'd23) state_d = DATA;
            default: ;
         endcase
      end
   end

   // Output and datapath next values: shift in on rise, shift out on fall,
   // reload the TX byte on the 8th rise of each response byte.
   always_comb begin
      rx_sr_d     = rx_sr_q;
      bit_cnt_d   = bit_cnt_q;
      tx_sr_d     = tx_sr_q;
      miso_d      = miso_q;
      oe_d        = oe_q;
      addr_d      = addr_q;
      cmd_d       = cmd_q;
      id_idx_d    = id_idx_q;
      mem_rd_d    = 1'b0;
      load_d      = mem_rd_q;
      cmd_valid_d = 1'b0;
      err_d       = 1'b0;

      if (load_q) tx_sr_d = mem_data_i;

      if (cs_n) begin
         bit_cnt_d = 5'd0;
         oe_d      = 1'b0;
         miso_d    = 1'b0;
      end else begin
         case (state_q)
            CMD: begin
               if (sck_rise) begin
                  rx_sr_d = rx_next[ADDR_W-2:0];
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d   = 5'd0;
                     cmd_d       = rx_next[7:0];
                     cmd_valid_d = 1'b1;
                     case (rx_next[7:0])
                        OP_READ: ;
                        OP_RDSR: tx_sr_d = STATUS;
                        OP_JEDEC: begin
                           tx_sr_d  = id_byte(JEDEC_ID, 2'd0);
                           id_idx_d = 2'd0;
                        end
                        default: err_d = 1'b1;
                     endcase
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end
            ADDR: begin
               if (sck_rise) begin
                  rx_sr_d = rx_next[ADDR_W-2:0];
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d = 5'd0;
                     addr_d    = rx_next;
                     mem_rd_d  = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end
            DATA, STAT, ID: begin
               if (sck_fall) begin
                  miso_d  = tx_sr_q[7];
                  tx_sr_d = {tx_sr_q[6:0], 1'b0};
                  oe_d    = 1'b1;
               end
               if (sck_rise) begin
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = 5'd0;
                     if (state_q == DATA) begin
                        addr_d   = addr_q + ADDR_W'(1);
                        mem_rd_d = 1'b1;
                     end else if (state_q == STAT) begin
                        tx_sr_d = STATUS;
                     end else begin
                        id_idx_d = id_idx_nxt;
                        tx_sr_d  = id_byte(JEDEC_ID, id_idx_nxt);
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_sr_q     <= '0;
         bit_cnt_q   <= 5'd0;
         tx_sr_q     <= 8'h00;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         addr_q      <= '0;
         mem_rd_q    <= 1'b0;
         load_q      <= 1'b0;
         cmd_q       <= 8'h00;
         cmd_valid_q <= 1'b0;
         err_q       <= 1'b0;
         id_idx_q    <= 2'd0;
      end else begin
         rx_sr_q     <= rx_sr_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_sr_q     <= tx_sr_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         addr_q      <= addr_d;
         mem_rd_q    <= mem_rd_d;
         load_q      <= load_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         err_q       <= err_d;
         id_idx_q    <= id_idx_d;
      end
   end

   assign spi_miso_o    = miso_q;
   assign spi_miso_oe_o = oe_q;
   assign mem_addr_o    = addr_q;
   assign mem_rd_o      = mem_rd_q;
   assign cmd_valid_o   = cmd_valid_q;
   assign cmd_o         = cmd_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized SPI master bench for spi_flash_responder against a transaction-level
// flash model (memory image, status byte, cyclic JEDEC id).
module tb_spi_flash_responder;

   localparam int          HALF   = 6;
   localparam int          AW     = 21;
   localparam logic [23:0] ID_VAL = 24'hBF2541;
   localparam logic [7:0]  ST_VAL = 8'h1C;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sck = 1'b0;
   logic          cs_n = 1'b1;
   logic          mosi = 1'b0;
   logic          miso, miso_oe, mem_rd, cmd_valid, err;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_data = 8'h00;
   logic [7:0]    cmd;

   int n_cmp = 0;
   int n_bad = 0;

   int cv_cnt = 0;
   int er_cnt = 0;
   int oe_cnt = 0;
   int rd_log[$];

   logic [7:0] mem_ov[int];

   always #5 clk = ~clk;

   spi_flash_responder dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .spi_sck_i     (sck),
      .spi_cs_ni     (cs_n),
      .spi_mosi_i    (mosi),
      .spi_miso_o    (miso),
      .spi_miso_oe_o (miso_oe),
      .mem_addr_o    (mem_addr),
      .mem_rd_o      (mem_rd),
      .mem_data_i    (mem_data),
      .cmd_valid_o   (cmd_valid),
      .cmd_o         (cmd),
      .err_o         (err)
   );

   function automatic logic [7:0] mem_val(input int a);
      if (mem_ov.exists(a)) return mem_ov[a];
      return 8'((a * 131) ^ (a >> 7) ^ 32'h5A);
   endfunction

   // Backing memory: registered read, data valid the cycle after the strobe.
   always @(posedge clk) if (mem_rd) mem_data <= mem_val(int'(mem_addr));

   always @(negedge clk) begin
      if (cmd_valid) cv_cnt++;
      if (err)       er_cnt++;
      if (miso_oe)   oe_cnt++;
      if (mem_rd)    rd_log.push_back(int'(mem_addr));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic sck_bit(input logic b, output logic r, output logic oe);
      @(negedge clk);
      mosi = b;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      r   = miso;
      oe  = miso_oe;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic xfer_byte(input logic [7:0] t, output logic [7:0] r, output bit oe_ok);
      logic rb, ob;
      oe_ok = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         sck_bit(t[i], rb, ob);
         r[i] = rb;
         if (ob !== 1'b1) oe_ok = 1'b0;
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_miso"},  32'(miso),      32'h0);
      chk({pfx, "_oe"},    32'(miso_oe),   32'h0);
      chk({pfx, "_addr"},  32'(mem_addr),  32'h0);
      chk({pfx, "_rd"},    32'(mem_rd),    32'h0);
      chk({pfx, "_cv"},    32'(cmd_valid), 32'h0);
      chk({pfx, "_cmd"},   32'(cmd),       32'h0);
      chk({pfx, "_err"},   32'(err),       32'h0);
   endtask

   task automatic end_cs();
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // One complete transaction: opcode, address for READ, then n response bytes.
   task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int n);
      int         cv0, er0, oe0, rd0;
      logic [7:0] r, exp;
      bit         ok;
      bit         known;
      int         base;
      known = (op == 8'h03) || (op == 8'h05) || (op == 8'h9F);
      base  = int'(addr) % (1 << AW);
      cv0 = cv_cnt; er0 = er_cnt; oe0 = oe_cnt; rd0 = rd_log.size();
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      xfer_byte(op, r, ok);
      if (op == 8'h03) begin
         xfer_byte(addr[23:16], r, ok);
         xfer_byte(addr[15:8],  r, ok);
         xfer_byte(addr[7:0],   r, ok);
      end
      for (int i = 0; i < n; i++) begin
         xfer_byte(8'($urandom), r, ok);
         if (known) begin
            if (op == 8'h03)      exp = mem_val((base + i) % (1 << AW));
            else if (op == 8'h05) exp = ST_VAL;
            else                  exp = 8'(ID_VAL >> (8 * (2 - (i % 3))));
            chk($sformatf("op%02h_rx%0d", op, i), 32'(r), 32'(exp));
            chk($sformatf("op%02h_oe%0d", op, i), 32'(ok), 32'h1);
         end
      end
      end_cs();
      chk($sformatf("op%02h_cmd_valid", op), 32'(cv_cnt - cv0), 32'h1);
      chk($sformatf("op%02h_cmd_o", op), 32'(cmd), 32'(op));
      chk($sformatf("op%02h_err", op), 32'(er_cnt - er0), known ? 32'h0 : 32'h1);
      chk($sformatf("op%02h_oe_off", op), 32'(miso_oe), 32'h0);
      if (!known) chk($sformatf("op%02h_oe_never", op), 32'(oe_cnt - oe0), 32'h0);
      if (op == 8'h03) begin
         chk("rd_count", 32'(rd_log.size() - rd0), 32'(n + 1));
         for (int i = 0; i <= n && rd0 + i < rd_log.size(); i++)
            chk($sformatf("rd_addr%0d", i), 32'(rd_log[rd0 + i]), 32'((base + i) % (1 << AW)));
      end else begin
         chk($sformatf("op%02h_no_rd", op), 32'(rd_log.size() - rd0), 32'h0);
      end
   endtask

   initial begin
      int         cv0, rd0, oe0;
      logic [7:0] r, op;
      logic       rb, ob;
      bit         ok;

      mem_ov[32'h10]     = 8'hA5;
      mem_ov[32'h11]     = 8'h3C;
      mem_ov[32'h1FFFFF] = 8'(($urandom % 255) + 1);
      mem_ov[32'h0]      = 8'(~mem_ov[32'h1FFFFF]);

      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      run_txn(8'h03, 24'h000010, 2);
      run_txn(8'h03, 24'h1FFFFF, 2);
      chk("wrap_addr_last", 32'(mem_addr), 32'h1);
      run_txn(8'h9F, 24'h0, 4);
      run_txn(8'h05, 24'h0, 2);
      run_txn(8'hAB, 24'h0, 2);

      // Abort after 12 address bits: no memory read may be issued.
      cv0 = cv_cnt; rd0 = rd_log.size();
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      xfer_byte(8'h03, r, ok);
      for (int i = 0; i < 12; i++) sck_bit(1'($urandom), rb, ob);
      end_cs();
      chk("abort_cmd_valid", 32'(cv_cnt - cv0), 32'h1);
      chk("abort_no_rd", 32'(rd_log.size() - rd0), 32'h0);
      run_txn(8'h03, 24'h000010, 1);

      // Reset mid-DATA with CS_n held low, then more clocks that must be ignored.
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      xfer_byte(8'h03, r, ok);
      xfer_byte(8'h00, r, ok);
      xfer_byte(8'h00, r, ok);
      xfer_byte(8'h10, r, ok);
      for (int i = 0; i < 4; i++) sck_bit(1'b0, rb, ob);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_vals("midrst");
      rst = 1'b0;
      cv0 = cv_cnt; rd0 = rd_log.size(); oe0 = oe_cnt;
      for (int i = 0; i < 12; i++) sck_bit(1'($urandom), rb, ob);
      end_cs();
      chk("midrst_no_cv", 32'(cv_cnt - cv0), 32'h0);
      chk("midrst_no_rd", 32'(rd_log.size() - rd0), 32'h0);
      chk("midrst_no_oe", 32'(oe_cnt - oe0), 32'h0);
      run_txn(8'h03, 24'h000010, 2);

      for (int k = 0; k < 20; k++) begin
         case ($urandom_range(0, 3))
            0: op = 8'h03;
            1: op = 8'h05;
            2: op = 8'h9F;
            default: begin
               op = 8'($urandom);
               if (op == 8'h03 || op == 8'h05 || op == 8'h9F) op = 8'hFF;
            end
         endcase
         run_txn(op, 24'($urandom), int'($urandom_range(1, 4)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
